// File: rtl/external_bus_sram_slave_if.sv
// Bus between the Avalon-to-external-bus bridge (master) and the SRAM slave.
interface external_bus_sram_slave_if #(
  parameter int DATA_BITS    = 16,
  parameter int BYTE_EN_BITS = 2
) ();
  logic [31:0]             address;
  logic                    bus_enable;
  logic [BYTE_EN_BITS-1:0] byte_enable;
  logic                    rw;
  logic [DATA_BITS-1:0]    write_data;
  logic                    acknowledge;
  logic [DATA_BITS-1:0]    read_data;

  modport master (
    output address, bus_enable, byte_enable, rw, write_data,
    input  acknowledge, read_data
  );

  modport slave (
    input  address, bus_enable, byte_enable, rw, write_data,
    output acknowledge, read_data
  );
endinterface

// File: rtl/external_bus_sram_slave.sv
// External-bus slave driving a 256Kx16 asynchronous SRAM. Each accepted bus
// request becomes one SRAM access of WAIT_STATES+1 cycles, followed by a
// one-cycle acknowledge (hold) and a release phase that waits for the bridge
// to drop bus_enable so that a request is never acknowledged twice.
module external_bus_sram_slave #(
  parameter int ADDR_BITS    = 18,
  parameter int DATA_BITS    = 16,
  parameter int ADDR_LOW     = 1,
  parameter int BYTE_EN_BITS = 2,
  parameter int WAIT_STATES  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  external_bus_sram_slave_if.slave    bus,
  output logic [ADDR_BITS-1:0]        sram_addr,
  inout  wire  [DATA_BITS-1:0]        sram_dq,
  output logic                        sram_ce_n,
  output logic                        sram_oe_n,
  output logic                        sram_we_n,
  output logic                        sram_ub_n,
  output logic                        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic [BYTE_EN_BITS-1:0] be_q, be_d;
  logic                    rw_q, rw_d;
  logic [DATA_BITS-1:0]    rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    ub_n_q, ub_n_d;
  logic                    lb_n_q, lb_n_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    hit;
  logic                    busy_d;

  // Only the low SRAM-sized window of the bus address space belongs to us.
  assign hit = (bus.address[31:ADDR_BITS+ADDR_LOW] == '0);

  // Next state plus registered outputs derived from the state being entered,
  // so every strobe is a flop and changes exactly at the state boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.bus_enable && hit) begin
          addr_d  = bus.address[ADDR_BITS+ADDR_LOW-1:ADDR_LOW];
          wdata_d = bus.write_data;
          be_d    = bus.byte_enable;
          rw_d    = bus.rw;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // The SRAM cycle always runs to completion; a bridge timeout only
        // suppresses the acknowledge.
        if (cnt_q == '0) begin
          if (rw_q) rdata_d = sram_dq;
          state_d = bus.bus_enable ? ACK : IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = bus.bus_enable ? RELEASE : IDLE;
      RELEASE: if (!bus.bus_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // ACK is a hold cycle: chip stays selected and write data stays on the
    // bus while OE/WE are already released.
    busy_d  = (state_d == ACCESS) || (state_d == ACK);
    ce_n_d  = !busy_d;
    oe_n_d  = !((state_d == ACCESS) && rw_d);
    we_n_d  = !((state_d == ACCESS) && !rw_d);
    ub_n_d  = busy_d ? (rw_d ? 1'b0 : !be_d[1]) : 1'b1;
    lb_n_d  = busy_d ? (rw_d ? 1'b0 : !be_d[0]) : 1'b1;
    dq_oe_d = busy_d && !rw_d;
    ack_d   = (state_d == ACK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign sram_dq         = dq_oe_q ? wdata_q : 'z;
  assign sram_addr       = addr_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_ub_n       = ub_n_q;
  assign sram_lb_n       = lb_n_q;
  assign bus.acknowledge = ack_q;
  assign bus.read_data   = rdata_q;

endmodule
